// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file dump reader.
// DUMP_CHECKSUM_EN adds the CSUM state used to emit the trailing XOR word.
package regfile_pkg;

    localparam int REG_IDX_W    = 5;
    localparam int NUM_REGS_DEF = 32;
    localparam int DATA_W_DEF   = 32;

`ifdef DUMP_CHECKSUM_EN
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        SEND = 3'd2,
        DONE = 3'd3,
        CSUM = 3'd4
    } dump_state_e;
`else
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        SEND = 3'd2,
        DONE = 3'd3
    } dump_state_e;
`endif

endpackage

// File: rtl/regfile_dump_reader.sv
// Walks register indices 0..NUM_REGS-1 through one read port and streams each word out on valid/ready.
// Optional macro DUMP_CHECKSUM_EN appends one XOR-of-all-words checksum word as the final beat.
//
// state | meaning
// IDLE  | waiting for start_i, read address parked at 0
// READ  | one cycle: drive index, capture read data into the output register
// SEND  | word valid, held until dump_ready_i
// CSUM  | one cycle: load accumulated XOR as the final word (DUMP_CHECKSUM_EN only)
// DONE  | one-cycle done_o pulse, then back to IDLE
module regfile_dump_reader
    import regfile_pkg::*;
#(
    parameter int N        = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_i,
    output logic [REG_IDX_W-1:0] Read_Register_o,
    input  logic [N-1:0]         Read_Data_i,
    output logic                 dump_valid_o,
    input  logic                 dump_ready_i,
    output logic [N-1:0]         dump_data_o,
    output logic [REG_IDX_W-1:0] dump_index_o,
    output logic                 dump_last_o,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam logic [REG_IDX_W-1:0] LAST_IDX = REG_IDX_W'(NUM_REGS - 1);

    dump_state_e          state_q, state_d;
    logic [REG_IDX_W-1:0] idx_q, idx_d;
    logic [N-1:0]         data_q, data_d;
    logic [REG_IDX_W-1:0] didx_q, didx_d;
    logic                 last_q, last_d;

`ifdef DUMP_CHECKSUM_EN
    logic [N-1:0]         csum_q, csum_d;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            didx_q  <= '0;
            last_q  <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            didx_q  <= didx_d;
            last_q  <= last_d;
`ifdef DUMP_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        didx_d  = didx_q;
        last_d  = last_q;
`ifdef DUMP_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = READ;
                    idx_d   = '0;
`ifdef DUMP_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            READ: begin
                data_d  = Read_Data_i;
                didx_d  = idx_q;
`ifdef DUMP_CHECKSUM_EN
                last_d  = 1'b0;
`else
                last_d  = (idx_q == LAST_IDX);
`endif
                state_d = SEND;
            end
            SEND: begin
                if (dump_ready_i) begin
`ifdef DUMP_CHECKSUM_EN
                    // The checksum word itself carries last and is never folded.
                    if (!last_q) begin
                        csum_d = csum_q ^ data_q;
                    end
`endif
                    if (last_q) begin
                        state_d = DONE;
                    end else if (idx_q == LAST_IDX) begin
`ifdef DUMP_CHECKSUM_EN
                        state_d = CSUM;
`else
                        state_d = DONE;
`endif
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = READ;
                    end
                end
            end
`ifdef DUMP_CHECKSUM_EN
            CSUM: begin
                // csum_q already includes the final register word folded at its handshake.
                data_d  = csum_q;
                didx_d  = '0;
                last_d  = 1'b1;
                state_d = SEND;
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign Read_Register_o = ((state_q == READ) || (state_q == SEND)) ? idx_q : '0;
    assign dump_valid_o    = (state_q == SEND);
    assign dump_data_o     = data_q;
    assign dump_index_o    = didx_q;
    assign dump_last_o     = last_q;
    assign busy_o          = (state_q != IDLE);
    assign done_o          = (state_q == DONE);

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader: behavioural register file, scoreboard of expected beats.
// Expectations follow DUMP_CHECKSUM_EN when the bench is built with that macro.
module tb_regfile_dump_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start_i = 1'b0;
    logic        dump_ready_i = 1'b0;
    logic [4:0]  Read_Register_o;
    logic [31:0] Read_Data_i;
    logic        dump_valid_o;
    logic [31:0] dump_data_o;
    logic [4:0]  dump_index_o;
    logic        dump_last_o;
    logic        busy_o;
    logic        done_o;

    regfile_dump_reader dut (
        .clk             (clk),
        .reset           (reset),
        .start_i         (start_i),
        .Read_Register_o (Read_Register_o),
        .Read_Data_i     (Read_Data_i),
        .dump_valid_o    (dump_valid_o),
        .dump_ready_i    (dump_ready_i),
        .dump_data_o     (dump_data_o),
        .dump_index_o    (dump_index_o),
        .dump_last_o     (dump_last_o),
        .busy_o          (busy_o),
        .done_o          (done_o)
    );

    always #5 clk = ~clk;

    logic [31:0] rf [32];
    assign Read_Data_i = rf[Read_Register_o];

`ifdef DUMP_CHECKSUM_EN
    localparam int EXP_DONE_CYC = 68;
`else
    localparam int EXP_DONE_CYC = 66;
`endif

    typedef struct packed {
        logic [31:0] d;
        logic [4:0]  i;
        logic        l;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    exp_t held;
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    logic done_prev = 1'b0;
    logic hold_prev = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: sampled on the falling edge, mid-cycle.
    always @(negedge clk) begin
        if (reset) begin
            if (done_o) check("done_single_cycle", 64'(done_prev), 64'd0);
            if (dump_valid_o && hold_prev) begin
                check("hold_data", 64'(dump_data_o), 64'(held.d));
                check("hold_index", 64'(dump_index_o), 64'(held.i));
                check("hold_last", 64'(dump_last_o), 64'(held.l));
            end
            if (dump_valid_o && dump_ready_i) begin
                checks++;
                assert (sb.size() > 0) else begin
                    errors++;
                    $error("FAIL sb_extra_word: observed index %0d data %0h, expected no word", dump_index_o, dump_data_o);
                end
                if (sb.size() > 0) begin
                    mon_e = sb.pop_front();
                    check("word_data", 64'(dump_data_o), 64'(mon_e.d));
                    check("word_index", 64'(dump_index_o), 64'(mon_e.i));
                    check("word_last", 64'(dump_last_o), 64'(mon_e.l));
                end
            end
            hold_prev = dump_valid_o && !dump_ready_i;
            held      = {dump_data_o, dump_index_o, dump_last_o};
            done_prev = done_o;
            if (done_o) done_cnt++;
        end else begin
            hold_prev = 1'b0;
            done_prev = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_dump();
        logic [31:0] x;
        x = '0;
        for (int i = 0; i < 32; i++) begin
            x = x ^ rf[i];
`ifdef DUMP_CHECKSUM_EN
            sb.push_back({rf[i], 5'(i), 1'b0});
`else
            sb.push_back({rf[i], 5'(i), (i == 31)});
`endif
        end
`ifdef DUMP_CHECKSUM_EN
        sb.push_back({x, 5'd0, 1'b1});
`endif
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_index(input int k, input string tag);
        int n;
        n = 0;
        while (!(dump_valid_o && dump_index_o == 5'(k)) && n < 200) begin
            tick();
            n++;
        end
        check(tag, 64'(dump_valid_o && dump_index_o == 5'(k)), 64'd1);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done_o && n < 300) begin
            tick();
            n++;
        end
        check(tag, 64'(done_o), 64'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_addr"}, 64'(Read_Register_o), 64'd0);
        check({tag, "_valid"}, 64'(dump_valid_o), 64'd0);
        check({tag, "_data"}, 64'(dump_data_o), 64'd0);
        check({tag, "_index"}, 64'(dump_index_o), 64'd0);
        check({tag, "_last"}, 64'(dump_last_o), 64'd0);
        check({tag, "_busy"}, 64'(busy_o), 64'd0);
        check({tag, "_done"}, 64'(done_o), 64'd0);
    endtask

    initial begin
        int cyc;
        int dc0;

        for (int i = 0; i < 32; i++) rf[i] = 32'hA000_0000 + i;

        // Reset values
        tick();
        tick();
        check_all_zero("reset");
        reset = 1'b1;
        tick();
        check_all_zero("idle");

        // Full dump, ready tied high; start_i high during cycle 1
        dump_ready_i = 1'b1;
        push_dump();
        pulse_start();
        cyc = 2;
        check("read_busy", 64'(busy_o), 64'd1);
        check("read_valid", 64'(dump_valid_o), 64'd0);
        check("read_addr", 64'(Read_Register_o), 64'd0);
        tick();
        cyc = 3;
        check("first_valid", 64'(dump_valid_o), 64'd1);
        check("first_index", 64'(dump_index_o), 64'd0);
        while (!done_o && cyc < 300) begin
            tick();
            cyc++;
        end
        check("done_cycle", 64'(cyc), 64'(EXP_DONE_CYC));
        check("done_busy", 64'(busy_o), 64'd1);
        tick();
        check("after_done_busy", 64'(busy_o), 64'd0);
        check("after_done_done", 64'(done_o), 64'd0);
        check("sb_empty_full", 64'(sb.size()), 64'd0);

        // Backpressure on index 7
        push_dump();
        pulse_start();
        wait_index(7, "reach_idx7");
        dump_ready_i = 1'b0;
        for (int j = 0; j < 5; j++) begin
            tick();
            check("bp_valid", 64'(dump_valid_o), 64'd1);
            check("bp_index", 64'(dump_index_o), 64'd7);
        end
        dump_ready_i = 1'b1;
        wait_done("bp_done");
        tick();
        check("sb_empty_bp", 64'(sb.size()), 64'd0);

        // start_i while busy is ignored
        dc0 = done_cnt;
        push_dump();
        pulse_start();
        wait_index(10, "reach_idx10");
        pulse_start();
        wait_done("restart_done");
        for (int j = 0; j < 5; j++) tick();
        check("restart_single_done", 64'(done_cnt - dc0), 64'd1);
        check("restart_idle_busy", 64'(busy_o), 64'd0);
        check("restart_idle_valid", 64'(dump_valid_o), 64'd0);
        check("sb_empty_restart", 64'(sb.size()), 64'd0);

        // Asynchronous reset in SEND at index 12
        push_dump();
        pulse_start();
        wait_index(12, "reach_idx12");
        reset = 1'b0;
        #1;
        check_all_zero("midreset");
        sb.delete();
        tick();
        reset = 1'b1;
        tick();
        push_dump();
        pulse_start();
        check("rst_restart_addr", 64'(Read_Register_o), 64'd0);
        tick();
        check("rst_restart_valid", 64'(dump_valid_o), 64'd1);
        check("rst_restart_index", 64'(dump_index_o), 64'd0);
        wait_done("rst_restart_done");
        tick();
        check("sb_empty_rst", 64'(sb.size()), 64'd0);

        // Boundary data values
        rf[0] = 32'h0000_0000;
        rf[1] = 32'hFFFF_FFFF;
        push_dump();
        pulse_start();
        wait_done("bound_done");
        tick();
        check("sb_empty_bound", 64'(sb.size()), 64'd0);

        // R[i] = i: XOR of all words is zero
        for (int i = 0; i < 32; i++) rf[i] = 32'(i);
        push_dump();
`ifdef DUMP_CHECKSUM_EN
        check("csum_model_zero", 64'(sb[32].d), 64'd0);
`endif
        pulse_start();
        wait_done("ramp_done");
        tick();
        check("sb_empty_ramp", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
